// File: rtl/rename_map.sv
// Register rename: RAT lookup with intra-group RAW/WAW bypass and circular free-list allocation; RENAME_FLUSH_EN adds committed RAT + flush recovery.
// Latency 1 cycle; in_ready drops while outputs are held (out_valid && !out_ready) or the free list cannot cover the group.
module rename_map #(
    parameter int WIDTH   = 4,
    parameter int PRF_NUM = 64,
    parameter int ARF_NUM = 32,
    parameter int PRF_W   = $clog2(PRF_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_lane_v,
    input  logic [WIDTH-1:0]       in_rd_wen,
    input  logic [WIDTH*5-1:0]     in_rs1,
    input  logic [WIDTH*5-1:0]     in_rs2,
    input  logic [WIDTH*5-1:0]     in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_lane_v,
    output logic [WIDTH*PRF_W-1:0] out_prs1,
    output logic [WIDTH*PRF_W-1:0] out_prs2,
    output logic [WIDTH*PRF_W-1:0] out_prd,
    output logic [WIDTH*PRF_W-1:0] out_preprd,
    input  logic [WIDTH-1:0]       cmt_valid,
    input  logic [WIDTH-1:0]       cmt_alloc,
    input  logic [WIDTH*5-1:0]     cmt_rd,
    input  logic [WIDTH*PRF_W-1:0] cmt_prd,
    input  logic [WIDTH*PRF_W-1:0] cmt_preprd,
    input  logic                   flush
);
    localparam int PTR_W = PRF_W + 1;

    logic [PRF_W-1:0] spec_rat [ARF_NUM];
    logic [PRF_W-1:0] freelist [PRF_NUM];
    logic [PTR_W-1:0] head, tail, free_cnt, n_alloc, n_rel;
    logic [WIDTH-1:0] alloc, rel_we;
    logic [PRF_W-1:0] prs1 [WIDTH];
    logic [PRF_W-1:0] prs2 [WIDTH];
    logic [PRF_W-1:0] prd [WIDTH];
    logic [PRF_W-1:0] preprd [WIDTH];
    logic [PRF_W-1:0] rel_idx [WIDTH];
    logic             flush_act, accept;

`ifdef RENAME_FLUSH_EN
    logic [PRF_W-1:0] cmt_rat [ARF_NUM];
    logic [PRF_W-1:0] cmt_rat_nxt [ARF_NUM];
    logic [PTR_W-1:0] cmt_head;
    assign flush_act = flush;
`else
    logic unused_cmt;
    assign unused_cmt = ^{flush, cmt_rd, cmt_prd};
    assign flush_act  = 1'b0;
`endif

    assign free_cnt = tail - head;
    assign in_ready = !flush_act && (!out_valid || out_ready) && (free_cnt >= n_alloc);
    assign accept   = in_valid && in_ready;

    // Later lanes override earlier matches, so each source sees the youngest older producer.
    always_comb begin
        logic [PTR_W-1:0] off;
        logic [4:0]       rd_i, rd_j;
        logic [PRF_W-1:0] idx;
        off   = '0;
        rd_j  = '0;
        alloc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rd_i      = in_rd[5*i +: 5];
            alloc[i]  = in_lane_v[i] && in_rd_wen[i] && (rd_i != 5'd0);
            idx       = head[PRF_W-1:0] + off[PRF_W-1:0];
            prd[i]    = alloc[i] ? freelist[idx] : '0;
            prs1[i]   = spec_rat[in_rs1[5*i +: 5]];
            prs2[i]   = spec_rat[in_rs2[5*i +: 5]];
            preprd[i] = spec_rat[rd_i];
            for (int j = 0; j < i; j++) begin
                rd_j = in_rd[5*j +: 5];
                if (alloc[j] && rd_j == in_rs1[5*i +: 5]) prs1[i] = prd[j];
                if (alloc[j] && rd_j == in_rs2[5*i +: 5]) prs2[i] = prd[j];
                if (alloc[j] && rd_j == rd_i)             preprd[i] = prd[j];
            end
            if (in_rs1[5*i +: 5] == 5'd0) prs1[i] = '0;
            if (in_rs2[5*i +: 5] == 5'd0) prs2[i] = '0;
            if (!alloc[i])                preprd[i] = '0;
            off = off + PTR_W'(alloc[i]);
        end
        n_alloc = off;
    end

    always_comb begin
        logic [PTR_W-1:0] k;
        k      = '0;
        rel_we = '0;
`ifdef RENAME_FLUSH_EN
        cmt_rat_nxt = cmt_rat;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            rel_we[i]  = cmt_valid[i] && cmt_alloc[i];
            rel_idx[i] = tail[PRF_W-1:0] + k[PRF_W-1:0];
`ifdef RENAME_FLUSH_EN
            if (rel_we[i]) cmt_rat_nxt[cmt_rd[5*i +: 5]] = cmt_prd[PRF_W*i +: PRF_W];
`endif
            k = k + PTR_W'(rel_we[i]);
        end
        n_rel = k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARF_NUM; i++) spec_rat[i] <= PRF_W'(i);
            for (int k = 0; k < PRF_NUM; k++)
                freelist[k] <= (k < PRF_NUM - ARF_NUM) ? PRF_W'(ARF_NUM + k) : '0;
            head       <= '0;
            tail       <= PTR_W'(PRF_NUM - ARF_NUM);
            out_valid  <= 1'b0;
            out_lane_v <= '0;
            out_prs1   <= '0;
            out_prs2   <= '0;
            out_prd    <= '0;
            out_preprd <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (rel_we[i]) freelist[rel_idx[i]] <= cmt_preprd[PRF_W*i +: PRF_W];
            tail <= tail + n_rel;
            if (flush_act) begin
`ifdef RENAME_FLUSH_EN
                spec_rat <= cmt_rat_nxt;
                head     <= cmt_head + n_rel;
`endif
                out_valid <= 1'b0;
            end else if (accept) begin
                head <= head + n_alloc;
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc[i]) spec_rat[in_rd[5*i +: 5]] <= prd[i];
                    out_prs1[PRF_W*i +: PRF_W]   <= prs1[i];
                    out_prs2[PRF_W*i +: PRF_W]   <= prs2[i];
                    out_prd[PRF_W*i +: PRF_W]    <= prd[i];
                    out_preprd[PRF_W*i +: PRF_W] <= preprd[i];
                end
                out_valid  <= 1'b1;
                out_lane_v <= in_lane_v;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RENAME_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARF_NUM; i++) cmt_rat[i] <= PRF_W'(i);
            cmt_head <= '0;
        end else begin
            cmt_rat  <= cmt_rat_nxt;
            cmt_head <= cmt_head + n_rel;
        end
    end
`endif
endmodule
